// File: rtl/float_convert_unit.sv
// float_convert_unit: pipelined integer<->float converter with valid/ready handshakes.
// The conversion is combinational in front of stage 0. Stages 1..STAGES-1 only add
// latency, and every stage register is elastic, so a stalled output backs up the pipe.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               kills every in-flight op and drops the input offered that cycle
//   in_valid/in_ready   input handshake; in_mode 0 = itof, 1 = ftoi
//   in_data, in_tag     operand and sideband tag, which travel together
//   out_valid/out_ready output handshake
//   out_data, out_tag   converted result and its tag
//   out_ovf             ftoi saturated or NaN input; always 0 for itof
module float_convert_unit #(
    parameter int unsigned INT_W  = 16,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MAN_W  = 7,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [INT_W-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf
);

    localparam int unsigned      FLT_W   = 1 + EXP_W + MAN_W;
    localparam int unsigned      BIAS    = (32'd1 << (EXP_W - 1)) - 32'd1;
    localparam logic [EXP_W-1:0] BIAS_X  = EXP_W'(BIAS);
    localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    // ---------------- itof ----------------
    logic             i_sign;
    logic [INT_W-1:0] i_mag;
    int unsigned      i_msb;
    logic [EXP_W-1:0] i_exp;
    logic [MAN_W-1:0] i_man;
    logic [FLT_W-1:0] i_flt;
    logic [INT_W-1:0] i_res;

    always_comb begin
        i_sign = in_data[INT_W-1];
        // The most negative input maps onto its own bit pattern, which is the correct unsigned magnitude.
        i_mag  = i_sign ? (~in_data + INT_W'(1)) : in_data;
        i_msb  = 32'd0;
        for (int unsigned b = 0; b < INT_W; b++) begin
            if (i_mag[b]) i_msb = b;
        end
        i_exp = EXP_W'(BIAS + i_msb);
        // Normalise the leading 1 to the MSB, then keep the MAN_W bits just below it (truncate).
        i_man = MAN_W'((i_mag << (INT_W - 1 - i_msb)) >> (INT_W - 1 - MAN_W));
        i_flt = {i_sign, i_exp, i_man};
        i_res = (in_data == '0) ? '0 : INT_W'(i_flt);
    end

    // ---------------- ftoi ----------------
    logic             f_s;
    logic [EXP_W-1:0] f_x;
    logic [MAN_W-1:0] f_m;
    int unsigned      f_e;
    logic [INT_W-1:0] f_sig;
    logic [INT_W-1:0] f_mag;
    logic [INT_W-1:0] f_res;
    logic             f_ovf;

    always_comb begin
        f_s   = in_data[FLT_W-1];
        f_x   = in_data[FLT_W-2 -: EXP_W];
        f_m   = in_data[MAN_W-1:0];
        f_e   = 32'(f_x) - BIAS;
        f_sig = INT_W'({1'b1, f_m});
        f_mag = (f_e >= MAN_W) ? (f_sig << (f_e - MAN_W)) : (f_sig >> (MAN_W - f_e));
        f_res = '0;
        f_ovf = 1'b0;
        if (f_x == '1) begin
            // NaN returns 0 and flags the overflow; infinity saturates.
            f_ovf = 1'b1;
            if (f_m == '0) f_res = f_s ? INT_MIN : INT_MAX;
        end else if (f_x >= BIAS_X) begin
            // Exponents below the bias (including zero/denormal) have magnitude < 1 and give 0.
            if (f_e >= INT_W - 1) begin
                f_res = f_s ? INT_MIN : INT_MAX;
                // Only exactly -2**(INT_W-1) is representable without saturating.
                f_ovf = !f_s || (f_e != INT_W - 1) || (f_m != '0);
            end else begin
                f_res = f_s ? (~f_mag + INT_W'(1)) : f_mag;
            end
        end
    end

    logic [INT_W-1:0] conv_data;
    logic             conv_ovf;

    assign conv_data = in_mode ? f_res : i_res;
    assign conv_ovf  = in_mode & f_ovf;

    // ---------------- elastic pipeline ----------------
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] load;
    logic [INT_W-1:0]  d_q [STAGES];
    logic [TAG_W-1:0]  t_q [STAGES];
    logic              o_q [STAGES];

    // A stage can load when it is empty or when its content moves on in the same cycle.
    always_comb begin
        load = '0;
        load[STAGES-1] = !v_q[STAGES-1] || out_ready;
        for (int unsigned k = 1; k < STAGES; k++) begin
            load[STAGES-1-k] = !v_q[STAGES-1-k] || load[STAGES-k];
        end
    end

    assign in_ready = load[0] && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
                t_q[k] <= '0;
                o_q[k] <= 1'b0;
            end
        end else begin
            if (load[0]) begin
                v_q[0] <= in_valid && !flush;
                d_q[0] <= conv_data;
                t_q[0] <= in_tag;
                o_q[0] <= conv_ovf;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    v_q[k] <= v_q[k-1];
                    d_q[k] <= d_q[k-1];
                    t_q[k] <= t_q[k-1];
                    o_q[k] <= o_q[k-1];
                end
            end
            // Flush overrides any valid bit loaded above.
            if (flush) v_q <= '0;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign out_tag   = t_q[STAGES-1];
    assign out_ovf   = o_q[STAGES-1];

endmodule
